// File: rtl/axi4_pkg.sv
// Shared response codes, read-path state encoding and address decode helper
// for the AXI4 register bank access scheduler.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_BANK,
        R_HOLD
    } rd_state_t;

    // Operands are widened to 64 bits so callers with any address width up to 64 can share it
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] lo,
                                      input logic [63:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin between write and read, with an optional
// fixed write-priority override.
module rr_arbiter2 #(
    parameter int WRITE_FIRST = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_w,
    input  logic req_r,
    output logic gnt_w,
    output logic gnt_r
);

    logic prefer_w;

    always_comb begin
        gnt_w = 1'b0;
        gnt_r = 1'b0;
        if (req_w && req_r) begin
            if ((WRITE_FIRST != 0) || prefer_w) begin
                gnt_w = 1'b1;
            end else begin
                gnt_r = 1'b1;
            end
        end else begin
            gnt_w = req_w;
            gnt_r = req_r;
        end
    end

    // Only contended grants move the pointer, so an idle side keeps its claim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_w <= 1'b1;
        end else if (req_w && req_r) begin
            prefer_w <= gnt_r;
        end
    end

endmodule

// File: rtl/axi4_regbank_arbiter.sv
// Schedules committed AXI4 write/read requests onto a single-port register bank
// and returns B and R responses, with address range decode.
module axi4_regbank_arbiter
    import axi4_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          ID_WIDTH    = 4,
    parameter int          RESP_WIDTH  = 2,
    parameter int          DEPTH       = 1024,
    parameter int          IDX_WIDTH   = $clog2(DEPTH),
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter logic [31:0] END_ADDR    = 32'h0000_03FF,
    parameter int          WRITE_FIRST = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ID_WIDTH-1:0]     wr_req_id,
    input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
    input  logic [DATA_WIDTH-1:0]   wr_req_data,
    input  logic [DATA_WIDTH/8-1:0] wr_req_strb,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ID_WIDTH-1:0]     rd_req_id,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    output logic                    bank_en,
    output logic                    bank_we,
    output logic [IDX_WIDTH-1:0]    bank_addr,
    output logic [DATA_WIDTH-1:0]   bank_wdata,
    output logic [DATA_WIDTH/8-1:0] bank_wstrb,
    input  logic [DATA_WIDTH-1:0]   bank_rdata,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [RESP_WIDTH-1:0]   b_resp,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [RESP_WIDTH-1:0]   r_resp
);

    rd_state_t             rd_state;
    rd_state_t             rd_state_next;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  gnt_w;
    logic                  gnt_r;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [ID_WIDTH-1:0]   rd_pend_id;
    logic                  rd_pend_ok;

    assign wr_ok  = in_range(64'(wr_req_addr), 64'(START_ADDR), 64'(END_ADDR));
    assign rd_ok  = in_range(64'(rd_req_addr), 64'(START_ADDR), 64'(END_ADDR));
    assign wr_idx = IDX_WIDTH'(wr_req_addr - ADDR_WIDTH'(START_ADDR));
    assign rd_idx = IDX_WIDTH'(rd_req_addr - ADDR_WIDTH'(START_ADDR));

    // A write may issue whenever its B slot is free or being drained this cycle
    assign wr_elig = wr_req_valid && (!b_valid || b_ready);
    assign rd_elig = rd_req_valid &&
                     ((rd_state == R_IDLE) || ((rd_state == R_HOLD) && r_ready));

    rr_arbiter2 #(
        .WRITE_FIRST (WRITE_FIRST)
    ) u_arb (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .req_w (wr_elig),
        .req_r (rd_elig),
        .gnt_w (gnt_w),
        .gnt_r (gnt_r)
    );

    assign wr_req_ready = gnt_w;
    assign rd_req_ready = gnt_r;

    assign bank_en    = (gnt_w && wr_ok) || (gnt_r && rd_ok);
    assign bank_we    = gnt_w && wr_ok;
    assign bank_addr  = gnt_r ? rd_idx : wr_idx;
    assign bank_wdata = wr_req_data;
    assign bank_wstrb = bank_we ? wr_req_strb : '0;

    assign r_valid = (rd_state == R_HOLD);

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            R_IDLE:  if (gnt_r) rd_state_next = R_BANK;
            R_BANK:  rd_state_next = R_HOLD;
            R_HOLD:  if (r_ready) rd_state_next = gnt_r ? R_BANK : R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Bank read data lands one cycle after the access, so the R registers load in R_BANK
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state   <= R_IDLE;
            rd_pend_id <= '0;
            rd_pend_ok <= 1'b0;
            r_id       <= '0;
            r_data     <= '0;
            r_resp     <= '0;
        end else begin
            rd_state <= rd_state_next;
            if (gnt_r) begin
                rd_pend_id <= rd_req_id;
                rd_pend_ok <= rd_ok;
            end
            if (rd_state == R_BANK) begin
                r_id   <= rd_pend_id;
                r_data <= rd_pend_ok ? bank_rdata : '0;
                r_resp <= rd_pend_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_DECERR);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            b_valid <= 1'b0;
            b_id    <= '0;
            b_resp  <= '0;
        end else if (gnt_w) begin
            b_valid <= 1'b1;
            b_id    <= wr_req_id;
            b_resp  <= wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_DECERR);
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_regbank_arbiter.sv
// Scoreboard bench: randomized write/read traffic against a per-address memory
// model, with grant policy, response timing and reset behaviour checked.
module tb_axi4_regbank_arbiter;

    localparam logic [31:0] TB_START = 32'h0000_0000;
    localparam logic [31:0] TB_END   = 32'h0000_03FF;

    logic        ACLK;
    logic        ARESETn;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [3:0]  wr_req_id;
    logic [31:0] wr_req_addr;
    logic [31:0] wr_req_data;
    logic [3:0]  wr_req_strb;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [3:0]  rd_req_id;
    logic [31:0] rd_req_addr;
    logic        bank_en;
    logic        bank_we;
    logic [9:0]  bank_addr;
    logic [31:0] bank_wdata;
    logic [3:0]  bank_wstrb;
    logic [31:0] bank_rdata;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    int          checks = 0;
    int          errors = 0;
    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    bit          exp_b_valid = 0;
    bit          rd_busy = 0;
    int          rd_age = 0;
    bit          prefer_w = 1;
    bit          stop_rand = 0;

    axi4_regbank_arbiter dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_id    (wr_req_id),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_strb  (wr_req_strb),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_id    (rd_req_id),
        .rd_req_addr  (rd_req_addr),
        .bank_en      (bank_en),
        .bank_we      (bank_we),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_wstrb   (bank_wstrb),
        .bank_rdata   (bank_rdata),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_id         (b_id),
        .b_resp       (b_resp),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_id         (r_id),
        .r_data       (r_data),
        .r_resp       (r_resp)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= TB_START) && (a <= TB_END);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                          input logic [3:0] strb);
        logic [31:0] res = old_d;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_d[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0:       return 32'h0000_0400 + ($urandom % 16);
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_03FF;
            default: return $urandom % 16;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port bank behaviour: sample the access mid-cycle, apply it on the next edge
    initial begin
        logic [31:0] bank_mem [0:1023];
        logic        s_en, s_we;
        logic [9:0]  s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_strb;
        for (int i = 0; i < 1024; i++) bank_mem[i] = '0;
        bank_rdata = '0;
        forever begin
            @(negedge ACLK);
            s_en = bank_en; s_we = bank_we; s_addr = bank_addr;
            s_wdata = bank_wdata; s_strb = bank_wstrb;
            @(posedge ACLK);
            if (s_en && s_we) bank_mem[s_addr] = merge(bank_mem[s_addr], s_wdata, s_strb);
            else if (s_en) bank_rdata <= bank_mem[s_addr];
        end
    end

    // Monitor and scoreboard: grant policy, bank access and responses against the model
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                b_q.delete();
                r_q.delete();
                exp_b_valid = 0;
                rd_busy     = 0;
                rd_age      = 0;
                prefer_w    = 1;
                check_output("rst_b_valid", 64'(b_valid), 64'(0));
                check_output("rst_r_valid", 64'(r_valid), 64'(0));
                check_output("rst_bank_en", 64'(bank_en), 64'(0));
                check_output("rst_bank_we", 64'(bank_we), 64'(0));
                check_output("rst_wr_ready", 64'(wr_req_ready), 64'(0));
                check_output("rst_rd_ready", 64'(rd_req_ready), 64'(0));
                check_output("rst_b_fields", 64'({b_id, b_resp}), 64'(0));
                check_output("rst_r_fields", 64'({r_id, r_data, r_resp}), 64'(0));
            end else begin
                bit          exp_r_valid;
                bit          w_el, r_el, gw, gr, exp_en;
                logic [31:0] a;
                exp_r_valid = rd_busy && (rd_age >= 2);

                check_output("b_valid", 64'(b_valid), 64'(exp_b_valid));
                if (exp_b_valid) begin
                    if (b_q.size() == 0) begin
                        check_output("b_queue_empty", 64'(0), 64'(1));
                    end else begin
                        check_output("b_id", 64'(b_id), 64'(b_q[0].id));
                        check_output("b_resp", 64'(b_resp), 64'(b_q[0].resp));
                    end
                end

                check_output("r_valid", 64'(r_valid), 64'(exp_r_valid));
                if (exp_r_valid) begin
                    if (r_q.size() == 0) begin
                        check_output("r_queue_empty", 64'(0), 64'(1));
                    end else begin
                        check_output("r_id", 64'(r_id), 64'(r_q[0].id));
                        check_output("r_data", 64'(r_data), 64'(r_q[0].data));
                        check_output("r_resp", 64'(r_resp), 64'(r_q[0].resp));
                    end
                end

                w_el = wr_req_valid && (!exp_b_valid || b_ready);
                r_el = rd_req_valid && (!rd_busy || (exp_r_valid && r_ready));
                gw = 0;
                gr = 0;
                if (w_el && r_el) begin
                    if (prefer_w) gw = 1;
                    else gr = 1;
                    prefer_w = gr;
                end else begin
                    gw = w_el;
                    gr = r_el;
                end
                check_output("wr_req_ready", 64'(wr_req_ready), 64'(gw));
                check_output("rd_req_ready", 64'(rd_req_ready), 64'(gr));

                a = gw ? wr_req_addr : rd_req_addr;
                exp_en = (gw || gr) && addr_ok(a);
                check_output("bank_en", 64'(bank_en), 64'(exp_en));
                if (exp_en) begin
                    check_output("bank_we", 64'(bank_we), 64'(gw));
                    check_output("bank_addr", 64'(bank_addr), 64'(10'(a - TB_START)));
                    if (gw) begin
                        check_output("bank_wdata", 64'(bank_wdata), 64'(wr_req_data));
                        check_output("bank_wstrb", 64'(bank_wstrb), 64'(wr_req_strb));
                    end
                end

                if (exp_b_valid && b_ready && b_q.size() > 0) void'(b_q.pop_front());
                if (exp_r_valid && r_ready) begin
                    if (r_q.size() > 0) void'(r_q.pop_front());
                    rd_busy = 0;
                end

                if (gw) begin
                    b_q.push_back('{id: wr_req_id,
                                    resp: addr_ok(wr_req_addr) ? 2'b00 : 2'b11});
                    if (addr_ok(wr_req_addr)) begin
                        ref_mem[wr_req_addr] = merge(ref_mem.exists(wr_req_addr) ?
                                                     ref_mem[wr_req_addr] : 32'h0,
                                                     wr_req_data, wr_req_strb);
                    end
                    exp_b_valid = 1;
                end else if (b_ready) begin
                    exp_b_valid = 0;
                end

                if (gr) begin
                    r_q.push_back('{id: rd_req_id,
                                    data: (addr_ok(rd_req_addr) && ref_mem.exists(rd_req_addr)) ?
                                          ref_mem[rd_req_addr] : 32'h0,
                                    resp: addr_ok(rd_req_addr) ? 2'b00 : 2'b11});
                    rd_busy = 1;
                    rd_age  = 0;
                end
                if (rd_busy && rd_age < 2) rd_age++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic apply_write(input logic [3:0] id, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
        bit accepted = 0;
        wr_req_valid = 1'b1;
        wr_req_id    = id;
        wr_req_addr  = addr;
        wr_req_data  = data;
        wr_req_strb  = strb;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge ACLK);
            accepted = wr_req_ready;
        end
        if (!accepted) check_output("wr_timeout", 64'(0), 64'(1));
        @(posedge ACLK);
        #1;
        wr_req_valid = 1'b0;
    endtask

    task automatic apply_read(input logic [3:0] id, input logic [31:0] addr);
        bit accepted = 0;
        rd_req_valid = 1'b1;
        rd_req_id    = id;
        rd_req_addr  = addr;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge ACLK);
            accepted = rd_req_ready;
        end
        if (!accepted) check_output("rd_timeout", 64'(0), 64'(1));
        @(posedge ACLK);
        #1;
        rd_req_valid = 1'b0;
    endtask

    initial begin
        ARESETn = 1'b0;
        wr_req_valid = 0; wr_req_id = 0; wr_req_addr = 0; wr_req_data = 0; wr_req_strb = 0;
        rd_req_valid = 0; rd_req_id = 0; rd_req_addr = 0;
        b_ready = 0; r_ready = 0;
        idle(3);
        ARESETn = 1'b1;
        b_ready = 1'b1;
        r_ready = 1'b1;

        apply_write(4'd3, 32'h10, 32'hDEAD_BEEF, 4'hF);
        apply_read(4'd5, 32'h10);
        idle(3);
        apply_write(4'd1, 32'h400, 32'h1111_2222, 4'hF);
        apply_read(4'd2, 32'hFFFF_FFFF);
        apply_write(4'd4, 32'h3FF, 32'h1234_5678, 4'h5);
        apply_read(4'd6, 32'h3FF);
        idle(3);

        fork
            repeat (4) apply_write(4'($urandom), $urandom % 16, $urandom, 4'hF);
            repeat (3) apply_read(4'($urandom), $urandom % 16);
        join
        idle(3);

        b_ready = 1'b0;
        apply_write(4'd7, 32'h20, 32'hA5A5_A5A5, 4'hF);
        fork
            apply_write(4'd8, 32'h21, 32'h5A5A_5A5A, 4'hF);
            begin
                idle(4);
                b_ready = 1'b1;
            end
        join
        idle(3);

        fork
            while (!stop_rand) begin
                idle(1);
                b_ready = ($urandom % 4) != 0;
                r_ready = ($urandom % 4) != 0;
            end
        join_none
        fork
            repeat (120) begin
                if ($urandom % 4 == 0) idle(1);
                else apply_write(4'($urandom), rand_addr(), $urandom, 4'($urandom));
            end
            repeat (120) begin
                if ($urandom % 4 == 0) idle(1);
                else apply_read(4'($urandom), rand_addr());
            end
        join
        stop_rand = 1;
        idle(2);
        b_ready = 1'b1;
        r_ready = 1'b1;
        idle(6);

        apply_read(4'd9, 32'h10);
        ARESETn = 1'b0;
        idle(2);
        ARESETn = 1'b1;
        idle(4);
        fork
            apply_write(4'd10, 32'h30, 32'hCAFE_F00D, 4'hF);
            apply_read(4'd11, 32'h30);
        join
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
